// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encodings for the serializer and the 101 detector
package seq_det_pkg;
  typedef enum logic {IDLE, SHIFT} ser_state_t;
  typedef enum logic [1:0] {D_S0, D_S1, D_S10, D_S101} det_state_t;
endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel word to gapless serial bit stream with flush and word counter
module seq_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             flush,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic [7:0]       word_cnt
);
  localparam int IW = $clog2(WIDTH);
  ser_state_t state;
  logic [WIDTH-1:0] sr;
  logic [IW-1:0] idx;
  logic last;
  logic accept;
  // the final bit of a word opens a one-cycle window for a gapless reload
  always_comb begin
    last = (state == SHIFT) && (idx == IW'(WIDTH - 1));
    load_ready = !flush && ((state == IDLE) || last);
    accept = load_valid && load_ready;
    ser_valid = (state == SHIFT);
    busy = (state == SHIFT);
    ser_out = (state == SHIFT) && sr[MSB_FIRST ? WIDTH-1 : 0];
  end
  // FSM, shift register, bit index and completed-word counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sr <= '0;
      idx <= '0;
      word_cnt <= '0;
    end else if (flush) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      if (last) word_cnt <= word_cnt + 8'd1;
      if (accept) begin
        sr <= data_in;
        idx <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
        idx <= last ? '0 : idx + IW'(1);
        state <= last ? IDLE : SHIFT;
      end
    end
  end
endmodule
